reg_file_8x8: RTL and testbench

- Clocked register file: four general registers R1–R4 and four temporary registers T1–T4, each WIDTH bits wide.
- Two independent combinational read ports, o1 and o2.
- One shared function select applies clear, load, decrement or increment to every register enabled by one-hot-style select masks.
- Sits in the datapath between the ALU-result/memory mux (driving load) and the ALU operand muxes (fed by o1/o2).

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_file_8x8_gp_register.sv | 41 ++++
 rtl/reg_file_8x8.sv | 67 ++++++
 tb/tb_reg_file_8x8.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared function-select and read-select codes for the reg_file_8x8 datapath register file.
package reg_file_pkg;

  localparam logic [1:0] FS_CLR  = 2'b00;
  localparam logic [1:0] FS_LOAD = 2'b01;
  localparam logic [1:0] FS_DEC  = 2'b10;
  localparam logic [1:0] FS_INC  = 2'b11;

  localparam logic [2:0] SEL_T1 = 3'b000;
  localparam logic [2:0] SEL_T2 = 3'b001;
  localparam logic [2:0] SEL_T3 = 3'b010;
  localparam logic [2:0] SEL_T4 = 3'b011;
  localparam logic [2:0] SEL_R1 = 3'b100;
  localparam logic [2:0] SEL_R2 = 3'b101;
  localparam logic [2:0] SEL_R3 = 3'b110;
  localparam logic [2:0] SEL_R4 = 3'b111;

endpackage

// File: rtl/reg_file_8x8_gp_register.sv
// Single general-purpose register with clear/load/decrement/increment.
// Define REG_FILE_SAT_EN to make increment/decrement saturate instead of wrap.
module gp_register
  import reg_file_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       funsel,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = q;
    unique case (funsel)
      FS_CLR:  q_next = '0;
      FS_LOAD: q_next = load;
`ifdef REG_FILE_SAT_EN
      FS_DEC:  q_next = (q == '0) ? q : q - 1'b1;
      FS_INC:  q_next = (q == '1) ? q : q + 1'b1;
`else
      FS_DEC:  q_next = q - 1'b1;
      FS_INC:  q_next = q + 1'b1;
`endif
      default: q_next = q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (enable)
      q <= q_next;
  end

endmodule

// File: rtl/reg_file_8x8.sv
// Register file: R1-R4 and T1-T4 with shared function select and two combinational read ports.
// Optional saturating arithmetic via REG_FILE_SAT_EN (see gp_register).
module reg_file_8x8
  import reg_file_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load,
  input  logic [1:0]       funsel,
  input  logic [3:0]       rsel,
  input  logic [3:0]       tsel,
  input  logic [2:0]       o1sel,
  input  logic [2:0]       o2sel,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2
);

  // Registers are stored in read-code order (T1..T4, R1..R4) so a port select indexes directly.
  logic [7:0]       en;
  logic [WIDTH-1:0] regs [8];

  assign en = {rsel[0], rsel[1], rsel[2], rsel[3], tsel[0], tsel[1], tsel[2], tsel[3]};

  for (genvar g = 0; g < 8; g++) begin : g_reg
    gp_register #(.WIDTH(WIDTH)) u_reg (
      .clk    (clk),
      .rst    (rst),
      .enable (en[g]),
      .funsel (funsel),
      .load   (load),
      .q      (regs[g])
    );
  end

  always_comb begin
    o1 = '0;
    unique case (o1sel)
      SEL_T1: o1 = regs[0];
      SEL_T2: o1 = regs[1];
      SEL_T3: o1 = regs[2];
      SEL_T4: o1 = regs[3];
      SEL_R1: o1 = regs[4];
      SEL_R2: o1 = regs[5];
      SEL_R3: o1 = regs[6];
      SEL_R4: o1 = regs[7];
      default: o1 = '0;
    endcase
  end

  always_comb begin
    o2 = '0;
    unique case (o2sel)
      SEL_T1: o2 = regs[0];
      SEL_T2: o2 = regs[1];
      SEL_T3: o2 = regs[2];
      SEL_T4: o2 = regs[3];
      SEL_R1: o2 = regs[4];
      SEL_R2: o2 = regs[5];
      SEL_R3: o2 = regs[6];
      SEL_R4: o2 = regs[7];
      default: o2 = '0;
    endcase
  end

endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed self-checking bench for reg_file_8x8 (both wrap and REG_FILE_SAT_EN builds).
module tb_reg_file_8x8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] load;
  logic [1:0] funsel;
  logic [3:0] rsel;
  logic [3:0] tsel;
  logic [2:0] o1sel;
  logic [2:0] o2sel;
  logic [7:0] o1;
  logic [7:0] o2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  reg_file_8x8 #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .funsel (funsel),
    .rsel   (rsel),
    .tsel   (tsel),
    .o1sel  (o1sel),
    .o2sel  (o2sel),
    .o1     (o1),
    .o2     (o2)
  );

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic do_write(input logic [3:0] rs, input logic [3:0] ts,
                          input logic [1:0] fs, input logic [7:0] ld);
    @(negedge clk);
    rsel = rs; tsel = ts; funsel = fs; load = ld;
    @(posedge clk);
    #1;
    rsel = 4'b0000; tsel = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 8'h00; funsel = 2'b00; rsel = 4'b0000; tsel = 4'b0000;
    o1sel = 3'd0; o2sel = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      o1sel = 3'(i); o2sel = 3'(7 - i);
      #1;
      checks++;
      if (o1 !== 8'h00 || o2 !== 8'h00)
        $display("FAIL reset_sel%0d: o1=%h o2=%h expected 00/00", i, o1, o2);
      else passed++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load();
    o1sel = 3'b101; o2sel = 3'b011;
    do_write(4'b0100, 4'b0001, 2'b01, 8'h95);
    checks++;
    if (o1 !== 8'h95 || o2 !== 8'h95)
      $display("FAIL load_r2_t4: o1=%h o2=%h expected 95/95", o1, o2);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      if (i != 5 && i != 3) begin
        o1sel = 3'(i);
        #1;
        checks++;
        if (o1 !== 8'h00) $display("FAIL load_other_sel%0d: o1=%h expected 00", i, o1);
        else passed++;
      end
    end
    o1sel = 3'b101;
  endtask

  task automatic test_increment();
    logic [7:0] exp;
    for (int k = 1; k <= 3; k++) begin
      exp = 8'(8'h95 + k);
      do_write(4'b0100, 4'b0001, 2'b11, 8'h00);
      checks++;
      if (o1 !== exp || o2 !== exp)
        $display("FAIL increment_%0d: o1=%h o2=%h expected %h", k, o1, o2, exp);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    o1sel = 3'b100; o2sel = 3'b100;
    do_write(4'b1000, 4'b0000, 2'b00, 8'h5A);
    checks++;
    if (o1 !== 8'h00) $display("FAIL clear_r1: o1=%h expected 00", o1);
    else passed++;
    do_write(4'b1000, 4'b0000, 2'b10, 8'h00);
`ifdef REG_FILE_SAT_EN
    exp = 8'h00;
`else
    exp = 8'hFF;
`endif
    checks++;
    if (o1 !== exp) $display("FAIL dec_from_00: o1=%h expected %h", o1, exp);
    else passed++;
    do_write(4'b1000, 4'b0000, 2'b01, 8'hFF);
    do_write(4'b1000, 4'b0000, 2'b11, 8'h00);
`ifdef REG_FILE_SAT_EN
    exp = 8'hFF;
`else
    exp = 8'h00;
`endif
    checks++;
    if (o1 !== exp) $display("FAIL inc_from_ff: o1=%h expected %h", o1, exp);
    else passed++;
    do_write(4'b1000, 4'b0000, 2'b01, 8'h01);
    do_write(4'b1000, 4'b0000, 2'b10, 8'h00);
    checks++;
    if (o1 !== 8'h00) $display("FAIL dec_from_01: o1=%h expected 00", o1);
    else passed++;
  endtask

  task automatic test_select();
    logic [7:0] e1;
    logic [7:0] e2;
    do_write(4'b0000, 4'b1000, 2'b01, 8'h11);
    do_write(4'b0000, 4'b0100, 2'b01, 8'h22);
    do_write(4'b0000, 4'b0010, 2'b01, 8'h33);
    do_write(4'b0000, 4'b0001, 2'b01, 8'h44);
    do_write(4'b1000, 4'b0000, 2'b01, 8'h55);
    do_write(4'b0100, 4'b0000, 2'b01, 8'h66);
    do_write(4'b0010, 4'b0000, 2'b01, 8'h77);
    do_write(4'b0001, 4'b0000, 2'b01, 8'h88);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        o1sel = 3'(i); o2sel = 3'(7 - i);
        e1 = 8'((i + 1) * 17);
        e2 = 8'((8 - i) * 17);
        #1;
        checks++;
        if (o1 !== e1 || o2 !== e2)
          $display("FAIL select_p%0d_sel%0d: o1=%h o2=%h expected %h/%h",
                   pass, i, o1, o2, e1, e2);
        else passed++;
      end
      if (pass == 0) do_write(4'b0000, 4'b0000, 2'b00, 8'hEE);
    end
    o1sel = 3'b110; o2sel = 3'b110;
    #1;
    checks++;
    if (o1 !== 8'h77 || o2 !== 8'h77)
      $display("FAIL same_sel: o1=%h o2=%h expected 77/77", o1, o2);
    else passed++;
  endtask

  task automatic test_multi_enable();
    do_write(4'b1111, 4'b1111, 2'b01, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      o1sel = 3'(i); o2sel = 3'(7 - i);
      #1;
      checks++;
      if (o1 !== 8'h3C || o2 !== 8'h3C)
        $display("FAIL multi_sel%0d: o1=%h o2=%h expected 3c/3c", i, o1, o2);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    o1sel = 3'b000; o2sel = 3'b111;
    @(negedge clk);
    #2;
    checks++;
    if (o1 !== 8'h3C || o2 !== 8'h3C)
      $display("FAIL pre_reset: o1=%h o2=%h expected 3c/3c", o1, o2);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (o1 !== 8'h00 || o2 !== 8'h00)
      $display("FAIL async_reset: o1=%h o2=%h expected 00/00", o1, o2);
    else passed++;
    rsel = 4'b1111; tsel = 4'b1111; funsel = 2'b01; load = 8'hAA;
    @(posedge clk);
    #1;
    checks++;
    if (o1 !== 8'h00 || o2 !== 8'h00)
      $display("FAIL reset_hold_edge: o1=%h o2=%h expected 00/00", o1, o2);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (o1 !== 8'h00) $display("FAIL post_release_no_edge: o1=%h expected 00", o1);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (o1 !== 8'hAA || o2 !== 8'hAA)
      $display("FAIL first_edge_after_reset: o1=%h o2=%h expected aa/aa", o1, o2);
    else passed++;
    rsel = 4'b0000; tsel = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_load();
    test_increment();
    test_wrap();
    test_select();
    test_multi_enable();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
